// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// WIDTH+1-bit trial subtractor: diff = a - b, non_neg set when a >= b (no borrow).
module div_trial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           non_neg
);

    logic [WIDTH+1:0] sum;

    // Carry out of a + ~b + 1 is the inverted borrow.
    assign sum     = {1'b0, a} + {1'b0, ~b} + {{(WIDTH + 1){1'b0}}, 1'b1};
    assign diff    = sum[WIDTH:0];
    assign non_neg = sum[WIDTH+1];

endmodule

// File: rtl/seq_divider_16bit.sv
// Restoring divider, one quotient bit per cycle behind a start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (sign fix-up on entry to DONE).
module seq_divider_16bit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             unused_trial_msb;

`ifdef SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
    logic ovf_pend;
`endif

    // dvd doubles as the quotient shift register: dividend bits leave the top,
    // quotient bits enter at the bottom.
    assign shifted = {rem, dvd[WIDTH-1]};

    div_trial_sub #(
        .WIDTH(WIDTH)
    ) u_trial_sub (
        .a      (shifted),
        .b      ({1'b0, dsr}),
        .diff   (trial),
        .non_neg(trial_ok)
    );

    assign unused_trial_msb = trial[WIDTH];
    assign q_next = {dvd[WIDTH-2:0], trial_ok};
    assign r_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_fix = q_next;
        r_fix = r_next;
`ifdef SIGNED_DIV_EN
        if (dividend[WIDTH-1]) a_mag = ~dividend + 1'b1;
        if (divisor[WIDTH-1])  b_mag = ~divisor + 1'b1;
        if (neg_q)             q_fix = ~q_next + 1'b1;
        if (neg_r)             r_fix = ~r_next + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= WIDTH'(DIV0_QUOTIENT);
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rem   <= '0;
                            dvd   <= a_mag;
                            dsr   <= b_mag;
                            cnt   <= CNT_W'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
                            neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r    <= dividend[WIDTH-1];
                            ovf_pend <= (dividend == {1'b1, {(WIDTH - 1){1'b0}}}) &&
                                        (divisor == '1);
`endif
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem <= r_next;
                    dvd <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_fix;
                        remainder <= r_fix;
`ifdef SIGNED_DIV_EN
                        overflow  <= ovf_pend;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
